// File: rtl/store_rmw_unit_pkg.sv
// Package: store_rmw_unit_pkg
// Shared definitions for the store read-modify-write path: store size encodings, the controller
// state enum, and helpers for lane merging and alignment checking. The lane-merge helper is
// written so a load-side aligner can reuse the same lane arithmetic.
package store_rmw_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StErr
    } state_e;

    // Little-endian lanes: offset 0 is bits [7:0], offset 3 is bits [31:24].
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  offset,
                                               input size_e       size);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{offset, 3'b000} +: 8]        = data[7:0];
            SZ_HALF: w[{offset[1], 4'b0000} +: 16]   = data[15:0];
            default: w                               = data;
        endcase
        return w;
    endfunction

    function automatic logic store_illegal(input size_e size, input logic [1:0] offset);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Module: store_lane_merge
// Combinational lane merger: replaces the byte or halfword lane(s) selected by offset in the
// old memory word with the low bits of data; a word store passes data straight through.
// Ports:
//   old_word  in   32  word read back from memory
//   data      in   32  register value to store
//   offset    in   2   byte offset within the word
//   size      in   2   store size (size_e)
//   merged    out  32  word to write back
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  size_e       size,
    output logic [31:0] merged
);

    always_comb begin
        merged = lane_merge(old_word, data, offset, size);
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Module: store_rmw_unit
// Narrows a 32-bit register value into a byte/half/word store for a word-only data memory.
// Word stores are written directly; byte/half stores read the word, merge the lane(s) and write
// the word back. Misaligned or illegal requests are dropped with an err pulse.
// Ports:
//   Clk, Reset                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_addr/req_size/req_data   byte address, size code, register value
//   mem_addr                     word address (0 while idle)
//   mem_rd_en/mem_rdata          one-cycle read strobe, data RD_LAT cycles later
//   mem_wr_en/mem_wdata          one-cycle write strobe and merged word
//   done/err                     one-cycle completion / drop pulses
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       merged;

    // Address bits beyond the memory size are ignored; the address wraps.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    store_lane_merge u_merge (
        .old_word (rdata_q),
        .data     (data_q),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .merged   (merged)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            data_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d = req_addr[ADDR_W+1:0];
                    size_d = size_e'(req_size);
                    data_d = req_data;
                    if (store_illegal(size_e'(req_size), req_addr[1:0])) begin
                        state_d = StErr;
                    end else if (size_e'(req_size) == SZ_WORD) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q[ADDR_W+1:2];
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                mem_addr = addr_q[ADDR_W+1:2];
                // Read data is valid during the RD_LAT-th cycle after the strobe.
                if (cnt_q == LAST_CNT) begin
                    rdata_d = mem_rdata;
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StWrite: begin
                mem_addr  = addr_q[ADDR_W+1:2];
                mem_wr_en = 1'b1;
                mem_wdata = merged;
                done      = 1'b1;
                state_d   = StIdle;
            end
            StErr: begin
                err     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
